regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file with an integrated busy-bit scoreboard for the MIPS datapath. It provides two asynchronous read ports, one posedge write port with optional write-to-read bypass, and a hardwired-zero register 0. A reservation port marks a destination register busy when an instruction issues. The matching writeback clears it, and decode uses the busy flags to stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- R0_ZERO, 1, 1 = register 0 reads 0; writes and reservations to it are ignored
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and busy flags

Ports:
- clk  in  1  clock; all state updates on posedge
- rstb  in  1  reset, synchronous, active-low
- rd_addr_1, rd_addr_2  in  ADDR_W  read addresses
- rd_data_1, rd_data_2  out  DATA_W  read data (combinational)
- rd_busy_1, rd_busy_2  out  1  scoreboard flag of the addressed register (combinational)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reservation request
- rsv_addr  in  ADDR_W  register to mark busy
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_count  out  ADDR_W+1  number of busy registers (registered)

## Operation
- Storage is 2**ADDR_W words of DATA_W bits, plus a 2**ADDR_W-bit busy vector and a busy_count register.
- **Reset.** On a posedge with rstb=0, all words, all busy bits and busy_count become 0. Reset overrides wr_en and rsv_en on that edge.
- **Reset outputs.** While rstb=0, rsv_ok=0. rd_data and rd_busy are still driven from state, so they read 0 after the first reset edge.
- **Write.** On a posedge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. The exception is wr_addr=0 with R0_ZERO=1: no effect.
- **Write to a non-busy register.** Legal; the data updates and busy_count is unchanged.
- **Read.** rd_data_n = mem[rd_addr_n], with two overrides:
  - R0_ZERO=1 and rd_addr_n=0: output is 0.
  - BYPASS=1, wr_en=1, wr_addr=rd_addr_n, and the write is not to R0-zero: output is wr_data.
- **Busy flag.** rd_busy_n = busy[rd_addr_n]. With BYPASS=1 it is forced to 0 when an effective write to that address happens this cycle. Register 0 always reads not-busy when R0_ZERO=1.
- **Reservation acceptance.** rsv_ok = rstb & rsv_en & ~(R0_ZERO & rsv_addr==0) & ~busy_eff[rsv_addr].
  - busy_eff is busy with the same-cycle effective write already applied.
  - So a reservation to a register being written back in the same cycle is accepted.
- **Accepted reservation.** On the posedge, busy[rsv_addr] <= 1. This overrides the write's clear when the addresses match, so the data is written and the register stays busy.
- **Rejected reservation.** Causes no state change. The issuing stage must hold its request and retry.
- **busy_count update.** busy_count(next) = busy_count + (rsv_ok ? 1 : 0) - (write clears a set bit ? 1 : 0).
  - A write and a reservation to the same busy register in the same cycle leave the count unchanged.
  - Invariant: busy_count always equals the popcount of the busy vector, and never exceeds 2**ADDR_W - R0_ZERO.

## Timing
- Read latency is 0 cycles: rd_data and rd_busy are combinational from the addresses, the state, and (when BYPASS=1) the write port.
- Write latency is 1 edge. With BYPASS=0, the new value is visible on the read ports only after the posedge.
- rsv_ok is valid in the same cycle as rsv_en. The busy bit is set at the next posedge.
- busy_count is registered and reflects the updates at the posedge following each event.
- No multi-cycle paths; there is one clock domain.
- rstb is sampled only at posedge. Asserting reset mid-operation discards any write or reservation in that cycle.

## Test plan
- **Reset and readback.** Hold rstb=0 for 2 cycles with wr_en=1, wr_addr=5. Then read addresses 0..31 -> all rd_data=0, all rd_busy=0, busy_count=0.
- **Write, read and R0.** Write 0xDEADBEEF to r7 and 0x12345678 to r0 (R0_ZERO=1).
  - Next cycle, r7 -> 0xDEADBEEF and r0 -> 0.
  - With BYPASS=1, in the write cycle itself rd_addr_1=7 -> 0xDEADBEEF.
  - With BYPASS=0, in the write cycle itself rd_addr_1=7 -> the old value.
- **Reserve and release.**
  - Reserve r3: rsv_ok=1, next cycle rd_busy(3)=1 and busy_count=1.
  - Reserve r3 again: rsv_ok=0, busy_count stays 1.
  - Write r3=0xA5: in that cycle rd_busy(3)=0 under BYPASS; after the edge busy_count=0.
- **Simultaneous write and reservation.** r4 is busy; in one cycle write r4=0x55 and reserve r4 -> rsv_ok=1, next cycle r4 reads 0x55, rd_busy(4)=1, busy_count unchanged.
- **Full scoreboard.** Reserve r1..r31 on consecutive cycles -> busy_count=31. Reserve r0 -> rsv_ok=0. Write back r31..r1 -> busy_count decrements to 0.
- **Reset mid-operation.** Set r2 busy and busy_count=1, then assert rstb=0 in the same cycle as a reservation of r6 -> rsv_ok=0, and after the edge all busy bits=0 and busy_count=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with busy-bit scoreboard, 2 async reads, 1 write.
// Ports: clk, rstb, rd_addr/data/busy x2, wr_en/addr/data, rsv_en/addr/ok, busy_count.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  busy_eff;
  logic [DEPTH-1:0]  wr_oh;
  logic [DEPTH-1:0]  rsv_oh;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              wr_eff;
  logic              wr_clr;
  logic              rsv_r0;

  assign wr_eff = wr_en &
    ~(R0_ZERO && (wr_addr == '0));
  assign rsv_r0 = R0_ZERO &&
    (rsv_addr == '0);

  assign wr_oh  = wr_eff ?
    (DEPTH'(1) << wr_addr) : '0;
  assign busy_eff = busy_q & ~wr_oh;

  assign rsv_ok = rstb & rsv_en &
    ~rsv_r0 & ~busy_eff[rsv_addr];
  assign rsv_oh = rsv_ok ?
    (DEPTH'(1) << rsv_addr) : '0;

  // reservation wins over writeback clear
  assign busy_d = busy_eff | rsv_oh;

  assign wr_clr = wr_eff & busy_q[wr_addr];
  assign cnt_d  = cnt_q
    + (ADDR_W+1)'(rsv_ok)
    - (ADDR_W+1)'(wr_clr);

  function automatic logic [DATA_W-1:0]
    rd_word(input logic [ADDR_W-1:0] a);
    if (R0_ZERO && a == '0)
      return '0;
    if (BYPASS && wr_eff && wr_addr == a)
      return wr_data;
    return mem_q[a];
  endfunction

  function automatic logic
    rd_flag(input logic [ADDR_W-1:0] a);
    if (R0_ZERO && a == '0)
      return 1'b0;
    if (BYPASS && wr_eff && wr_addr == a)
      return 1'b0;
    return busy_q[a];
  endfunction

  assign rd_data_1  = rd_word(rd_addr_1);
  assign rd_data_2  = rd_word(rd_addr_2);
  assign rd_busy_1  = rd_flag(rd_addr_1);
  assign rd_busy_2  = rd_flag(rd_addr_2);
  assign busy_count = cnt_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (wr_eff) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb.
// Two instances: bypass on (main) and bypass off (read port 1 only).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rstb;
  logic [4:0]  rd_addr_1, rd_addr_2;
  logic [31:0] rd_data_1, rd_data_2;
  logic        rd_busy_1, rd_busy_2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [5:0]  busy_count;

  logic [31:0] nb_d1, nb_d2;
  logic        nb_b1, nb_b2, nb_ok;
  logic [5:0]  nb_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rstb(rstb),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .busy_count(busy_count)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rstb(rstb),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(nb_d1), .rd_data_2(nb_d2),
    .rd_busy_1(nb_b1), .rd_busy_2(nb_b2),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(nb_ok), .busy_count(nb_cnt)
  );

  typedef struct {
    logic [31:0] d1, d2, nd1;
    logic        b1, b2, ok;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [32];
  logic [31:0] busy_m;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, obs, exp);
    end
  endtask

  function automatic logic wr_hit(input logic [4:0] a);
    return wr_en && wr_addr != 0 && wr_addr == a;
  endfunction

  function automatic logic [31:0] m_rd(
    input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wr_hit(a)) return wr_data;
    return mem_m[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0 || wr_hit(a)) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic logic m_ok();
    if (!rstb || !rsv_en || rsv_addr == 0) return 1'b0;
    if (wr_hit(rsv_addr)) return 1'b1;
    return !busy_m[rsv_addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 0;
    busy_m = 0;
  endtask

  task automatic step();
    exp_t e, g;
    logic ok;
    #2;
    e.d1  = m_rd(rd_addr_1, 1'b1);
    e.d2  = m_rd(rd_addr_2, 1'b1);
    e.nd1 = m_rd(rd_addr_1, 1'b0);
    e.b1  = m_busy(rd_addr_1);
    e.b2  = m_busy(rd_addr_2);
    e.ok  = m_ok();
    e.cnt = 6'($countones(busy_m));
    sbq.push_back(e);
    g = sbq.pop_front();
    chk("rd_data_1", rd_data_1, g.d1);
    chk("rd_data_2", rd_data_2, g.d2);
    chk("nb_data_1", nb_d1, g.nd1);
    chk("rd_busy_1", 32'(rd_busy_1), 32'(g.b1));
    chk("rd_busy_2", 32'(rd_busy_2), 32'(g.b2));
    chk("rsv_ok", 32'(rsv_ok), 32'(g.ok));
    chk("busy_count", 32'(busy_count), 32'(g.cnt));
    ok = e.ok;
    @(posedge clk);
    if (!rstb) begin
      model_reset();
    end else begin
      if (wr_en && wr_addr != 0) begin
        mem_m[wr_addr]  = wr_data;
        busy_m[wr_addr] = 1'b0;
      end
      if (ok) busy_m[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rstb = 1; wr_en = 0; rsv_en = 0;
  endtask

  task automatic do_wr(input logic [4:0] a,
                       input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_rsv(input logic [4:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask

  initial begin
    rstb = 0; wr_en = 1; wr_addr = 5;
    wr_data = 32'hFFFF_FFFF;
    rsv_en = 0; rsv_addr = 0;
    rd_addr_1 = 0; rd_addr_2 = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      rd_addr_1 = 5'(i);
      rd_addr_2 = 5'(31 - i);
      step();
    end

    rd_addr_1 = 7; rd_addr_2 = 0;
    do_wr(7, 32'hDEAD_BEEF); step();
    rd_addr_1 = 0;
    do_wr(0, 32'h1234_5678); step();
    idle();
    rd_addr_1 = 7; rd_addr_2 = 0; step();

    rd_addr_1 = 3;
    do_rsv(3); step();
    step();
    idle();
    do_wr(3, 32'hA5); step();
    idle(); step();

    rd_addr_1 = 4;
    do_rsv(4); step();
    do_wr(4, 32'h55); do_rsv(4); step();
    idle(); step();

    for (int i = 1; i < 32; i++) begin
      idle();
      rd_addr_2 = 5'(i);
      do_rsv(5'(i)); step();
    end
    idle(); do_rsv(0); step();
    for (int i = 31; i > 0; i--) begin
      idle();
      rd_addr_1 = 5'(i);
      do_wr(5'(i), 32'(i * 3)); step();
    end
    idle(); step();

    rd_addr_1 = 2; rd_addr_2 = 6;
    do_rsv(2); step();
    idle(); rstb = 0; do_rsv(6);
    do_wr(9, 32'h99); step();
    idle(); step();

    for (int n = 0; n < 300; n++) begin
      rstb      = ($urandom_range(0, 49) != 0);
      wr_en     = 1'($urandom);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      rsv_en    = 1'($urandom);
      rsv_addr  = 5'($urandom);
      rd_addr_1 = ($urandom_range(0, 3) == 0)
                  ? wr_addr : 5'($urandom);
      rd_addr_2 = 5'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
